// File: rtl/tart_clk_pkg.sv
// Shared definitions for the DCM lock supervisor: sequencing states and
// counter sizing helpers.
package tart_clk_pkg;

   localparam int STATE_W = 3;
   localparam int RETRY_W = 4;

   typedef enum logic [STATE_W-1:0] {
      RESET_DCM = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } sup_state_e;

   // One spare bit so the largest terminal count never sits on the top code.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/tart_sync2.sv
// Two-flop synchroniser for quasi-static status flags crossing into the
// reference clock domain; no reset so the chain never masks a live flag.
module tart_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk) begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
   end

   assign q = sync_p1;

endmodule

// File: rtl/tart_lock_supervisor.sv
// Reset sequencer for NUM_DCM clock managers: pulses DCM resets, qualifies
// lock, releases the system reset and recovers from run-time lock loss.
module tart_lock_supervisor
   import tart_clk_pkg::*;
#(
   parameter int                 NUM_DCM       = 2,
   parameter logic [NUM_DCM-1:0] LOCK_MASK     = {NUM_DCM{1'b1}},
   parameter int                 RST_CYCLES    = 8,
   parameter int                 LOCK_TIMEOUT  = 65535,
   parameter int                 STABLE_CYCLES = 1023,
   parameter int                 MAX_RETRIES   = 3,
   parameter int                 CNT_W         = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_DCM-1:0] locked_i,
   input  logic [NUM_DCM-1:0] stopped_i,
   input  logic               retry_i,
   output logic [NUM_DCM-1:0] dcm_rst_o,
   output logic               sys_rst_o,
   output logic               locked_o,
   output logic               fault_o,
   output logic [RETRY_W-1:0] retries_o,
   output logic [CNT_W-1:0]   losses_o
);

   localparam int TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   logic [NUM_DCM-1:0] lk_s;
   logic [NUM_DCM-1:0] st_s;
   logic               good;

   sup_state_e         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [RETRY_W-1:0] retries_q, retries_d, retries_inc;
   logic [CNT_W-1:0]   losses_q, losses_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   tart_sync2 #(.WIDTH(NUM_DCM)) u_sync_locked (
      .clk (clk_i),
      .d   (locked_i),
      .q   (lk_s)
   );

   tart_sync2 #(.WIDTH(NUM_DCM)) u_sync_stopped (
      .clk (clk_i),
      .d   (stopped_i),
      .q   (st_s)
   );

   // Masked DCMs are neither required to lock nor allowed to flag a stopped clock.
   assign good        = (&(lk_s | ~LOCK_MASK)) & ~(|(st_s & LOCK_MASK));
   assign retries_inc = retries_q + RETRY_W'(1);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      retries_d = retries_q;
      losses_d  = losses_q;
      case (state_q)
         RESET_DCM: begin
            if (timer_q == RST_LAST) begin
               timer_d = '0;
               state_d = WAIT_LOCK;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (good) begin
               timer_d = '0;
               state_d = STABLE;
            end else if (timer_q == TIMEOUT_LAST) begin
               timer_d   = '0;
               retries_d = retries_inc;
               state_d   = (retries_inc == RETRY_LIMIT) ? FAULT : RESET_DCM;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         STABLE: begin
            // A dropout here is treated as settling, not as a failed attempt.
            if (!good) begin
               timer_d = '0;
               state_d = WAIT_LOCK;
            end else if (timer_q == STABLE_LAST) begin
               timer_d   = '0;
               retries_d = '0;
               state_d   = RUN;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         RUN: begin
            if (!good) begin
               losses_d = sat_inc(losses_q);
               timer_d  = '0;
               state_d  = RESET_DCM;
            end
         end
         FAULT: begin
            if (retry_i) begin
               retries_d = '0;
               timer_d   = '0;
               state_d   = RESET_DCM;
            end
         end
         default: begin
            timer_d = '0;
            state_d = RESET_DCM;
         end
      endcase
   end

   // Outputs are decoded from the next state so they flip with the state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RESET_DCM;
         timer_q   <= '0;
         retries_q <= '0;
         losses_q  <= '0;
         dcm_rst_o <= '1;
         sys_rst_o <= 1'b1;
         locked_o  <= 1'b0;
         fault_o   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retries_q <= retries_d;
         losses_q  <= losses_d;
         dcm_rst_o <= ((state_d == RESET_DCM) || (state_d == FAULT)) ? '1 : '0;
         sys_rst_o <= (state_d != RUN);
         locked_o  <= (state_d == RUN);
         fault_o   <= (state_d == FAULT);
      end
   end

   assign retries_o = retries_q;
   assign losses_o  = losses_q;

endmodule

// File: tb/tb_tart_lock_supervisor.sv
// Bench for tart_lock_supervisor: two instances (full mask and DCM1 masked)
// checked every cycle against a phase/countdown reference model.
module tb_tart_lock_supervisor;

   localparam int RSTC = 8;
   localparam int LTO  = 100;
   localparam int STB  = 40;
   localparam int MAXR = 3;
   localparam int CW   = 2;

   localparam int PH_RST  = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_STAB = 2;
   localparam int PH_RUN  = 3;
   localparam int PH_FLT  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] locked;
   logic [1:0] locked_m;
   logic [1:0] stopped;
   logic       retry;
   bit         chk_en;

   logic [1:0]    dcm_rst_w [2];
   logic          sys_rst_w [2];
   logic          lock_w    [2];
   logic          fault_w   [2];
   logic [3:0]    retries_w [2];
   logic [CW-1:0] losses_w  [2];

   int n_cmp;
   int n_bad;

   int ph        [2];
   int left      [2];
   int m_retries [2];
   int m_losses  [2];
   bit gd0       [2];
   bit gd1       [2];

   always #5 clk = ~clk;

   assign locked_m = {1'b0, locked[0]};

   tart_lock_supervisor #(
      .NUM_DCM(2), .LOCK_MASK(2'b11), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO),
      .STABLE_CYCLES(STB), .MAX_RETRIES(MAXR), .CNT_W(CW)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .locked_i(locked), .stopped_i(stopped), .retry_i(retry),
      .dcm_rst_o(dcm_rst_w[0]), .sys_rst_o(sys_rst_w[0]), .locked_o(lock_w[0]),
      .fault_o(fault_w[0]), .retries_o(retries_w[0]), .losses_o(losses_w[0])
   );

   tart_lock_supervisor #(
      .NUM_DCM(2), .LOCK_MASK(2'b01), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO),
      .STABLE_CYCLES(STB), .MAX_RETRIES(MAXR), .CNT_W(CW)
   ) u_dut_m (
      .clk_i(clk), .rst_i(rst), .locked_i(locked_m), .stopped_i(stopped), .retry_i(retry),
      .dcm_rst_o(dcm_rst_w[1]), .sys_rst_o(sys_rst_w[1]), .locked_o(lock_w[1]),
      .fault_o(fault_w[1]), .retries_o(retries_w[1]), .losses_o(losses_w[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_good(input logic [1:0] lk, input logic [1:0] st,
                                     input logic [1:0] mask);
      bit ok;
      ok = 1'b1;
      for (int n = 0; n < 2; n++)
         if (mask[n] && (!lk[n] || st[n])) ok = 1'b0;
      return ok;
   endfunction

   // Reference: each phase holds a count of cycles still to spend in it.
   task automatic model_step(input int m);
      bit g;
      g = gd1[m];
      if (rst) begin
         ph[m] = PH_RST; left[m] = RSTC; m_retries[m] = 0; m_losses[m] = 0;
      end else begin
         case (ph[m])
            PH_RST: begin
               left[m]--;
               if (left[m] == 0) begin ph[m] = PH_WAIT; left[m] = LTO; end
            end
            PH_WAIT: begin
               if (g) begin
                  ph[m] = PH_STAB; left[m] = STB;
               end else begin
                  left[m]--;
                  if (left[m] == 0) begin
                     m_retries[m]++;
                     if (m_retries[m] == MAXR) ph[m] = PH_FLT;
                     else begin ph[m] = PH_RST; left[m] = RSTC; end
                  end
               end
            end
            PH_STAB: begin
               if (!g) begin
                  ph[m] = PH_WAIT; left[m] = LTO;
               end else begin
                  left[m]--;
                  if (left[m] == 0) begin ph[m] = PH_RUN; m_retries[m] = 0; end
               end
            end
            PH_RUN: begin
               if (!g) begin
                  if (m_losses[m] < (1 << CW) - 1) m_losses[m]++;
                  ph[m] = PH_RST; left[m] = RSTC;
               end
            end
            default: begin
               if (retry) begin m_retries[m] = 0; ph[m] = PH_RST; left[m] = RSTC; end
            end
         endcase
      end
      gd1[m] = gd0[m];
      gd0[m] = model_good((m == 0) ? locked : locked_m, stopped, (m == 0) ? 2'b11 : 2'b01);
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("i%0d dcm_rst", m), dcm_rst_w[m],
                     ((ph[m] == PH_RST) || (ph[m] == PH_FLT)) ? 2'b11 : 2'b00);
            check_eq($sformatf("i%0d sys_rst", m), sys_rst_w[m], ph[m] != PH_RUN);
            check_eq($sformatf("i%0d locked", m), lock_w[m], ph[m] == PH_RUN);
            check_eq($sformatf("i%0d fault", m), fault_w[m], ph[m] == PH_FLT);
            check_eq($sformatf("i%0d retries", m), retries_w[m], m_retries[m]);
            check_eq($sformatf("i%0d losses", m), losses_w[m], m_losses[m]);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      for (int m = 0; m < 2; m++) begin
         check_eq($sformatf("%s i%0d dcm_rst", tag, m), dcm_rst_w[m], 2'b11);
         check_eq($sformatf("%s i%0d sys_rst", tag, m), sys_rst_w[m], 1'b1);
         check_eq($sformatf("%s i%0d locked", tag, m), lock_w[m], 1'b0);
         check_eq($sformatf("%s i%0d fault", tag, m), fault_w[m], 1'b0);
         check_eq($sformatf("%s i%0d retries", tag, m), retries_w[m], 0);
         check_eq($sformatf("%s i%0d losses", tag, m), losses_w[m], 0);
      end
   endtask

   task automatic wait_dcm_fall(output int cnt);
      cnt = 0;
      while (dcm_rst_w[0] == 2'b11 && cnt < 50) begin cnt++; @(negedge clk); end
   endtask

   task automatic measure_release(output int cnt);
      cnt = 0;
      while (sys_rst_w[0] && cnt < 1000) begin @(negedge clk); cnt++; end
   endtask

   task automatic wait_run(input string tag);
      int n;
      n = 0;
      while (lock_w[0] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      check_eq(tag, lock_w[0], 1'b1);
   endtask

   task automatic pulse_stop(input int bitn, output int lat);
      stopped[bitn] = 1'b1;
      @(negedge clk);
      stopped[bitn] = 1'b0;
      lat = 1;
      while (sys_rst_w[0] == 1'b0 && lat < 10) begin @(negedge clk); lat++; end
   endtask

   initial begin
      int  cnt;
      int  lat;
      int  rises;
      int  last;
      int  cyc;
      bit  prev_hi;
      n_cmp = 0; n_bad = 0; chk_en = 1'b0;
      rst = 1'b1; locked = 2'b00; stopped = 2'b00; retry = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      // Release sequence
      wait_dcm_fall(cnt);
      check_eq("dcm_rst width", cnt, RSTC);
      repeat (20) @(negedge clk);
      locked = 2'b11;
      measure_release(cnt);
      // Flag driven half a cycle before its first sampling edge: SC+2 edges after that edge.
      check_eq("release delay", cnt, STB + 3);
      check_eq("release locked i0", lock_w[0], 1'b1);
      check_eq("release locked i1", lock_w[1], 1'b1);
      check_eq("release retries", retries_w[0], 0);

      // Glitch during qualification
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_dcm_fall(cnt);
      repeat ($urandom_range(8, 30)) @(negedge clk);
      locked[1] = 1'b0;
      @(negedge clk);
      locked[1] = 1'b1;
      check_eq("glitch still held", sys_rst_w[0], 1'b1);
      measure_release(cnt);
      check_eq("glitch release delay", cnt, STB + 3);
      check_eq("glitch retries", retries_w[0], 0);
      check_eq("glitch masked inst run", lock_w[1], 1'b1);

      // Run-time loss via stopped clock on DCM0
      pulse_stop(0, lat);
      check_eq("loss latency<=3", lat <= 3, 1'b1);
      check_eq("loss count i0", losses_w[0], 1);
      check_eq("loss count i1", losses_w[1], 1);
      wait_run("resequence run");

      // DCM1 event: masked instance must ignore it
      pulse_stop(1, lat);
      check_eq("dcm1 loss latency", lat <= 3, 1'b1);
      check_eq("dcm1 loss i0", losses_w[0], 2);
      check_eq("dcm1 ignored losses", losses_w[1], 1);
      check_eq("dcm1 ignored locked", lock_w[1], 1'b1);
      wait_run("dcm1 rerun");

      // Saturation of the loss counter
      repeat (3) begin
         pulse_stop(0, lat);
         wait_run("sat rerun");
      end
      check_eq("sat losses i0", losses_w[0], 3);
      check_eq("sat losses i1", losses_w[1], 3);

      // Reset while running
      rst = 1'b1;
      locked = 2'b00;
      @(negedge clk);
      check_reset_vals("rst in run");
      rst = 1'b0;

      // Timeout and bounded retry
      rises = 0; last = 0; cyc = 0; prev_hi = 1'b1;
      while (!fault_w[0] && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (dcm_rst_w[0] == 2'b11 && !prev_hi) begin
            rises++;
            check_eq($sformatf("retry spacing %0d", rises), cyc - last, RSTC + LTO);
            check_eq($sformatf("retry step %0d", rises), retries_w[0], rises);
            last = cyc;
         end
         prev_hi = (dcm_rst_w[0] == 2'b11);
      end
      check_eq("timeout rises", rises, MAXR);
      repeat (5) @(negedge clk);
      check_eq("fault held", fault_w[0], 1'b1);
      check_eq("fault dcm_rst", dcm_rst_w[0], 2'b11);
      check_eq("fault retries", retries_w[0], MAXR);
      retry = 1'b1;
      @(negedge clk);
      retry = 1'b0;
      check_eq("retry leaves fault", fault_w[0], 1'b0);
      check_eq("retry clears count", retries_w[0], 0);
      check_eq("retry re-resets dcm", dcm_rst_w[0], 2'b11);

      // Randomized operation against the reference model
      locked = 2'b11;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 599) == 0);
         retry = ($urandom_range(0, 29) == 0);
         for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 99) == 0) locked[b] = ~locked[b];
            if (stopped[b]) stopped[b] = ($urandom_range(0, 2) != 0);
            else            stopped[b] = ($urandom_range(0, 299) == 0);
         end
      end
      @(negedge clk);
      rst = 1'b0; retry = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
